// File: rtl/eeprom_arbiter.sv
// rtl/eeprom_arbiter.sv - two-port round-robin arbiter/sequencer for the I2C EEPROM engine
module eeprom_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int WR_GAP  = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        A_REQ,
  input  logic        A_WE,
  input  logic [10:0] A_ADDR,
  input  logic [7:0]  A_WDATA,
  output logic        A_DONE,
  output logic        A_ERR,
  output logic [7:0]  A_RDATA,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [10:0] B_ADDR,
  input  logic [7:0]  B_WDATA,
  output logic        B_DONE,
  output logic        B_ERR,
  output logic [7:0]  B_RDATA,
  output logic        E_WR,
  output logic        E_RD,
  output logic [10:0] E_ADDR,
  inout  wire  [7:0]  E_DATA,
  input  logic        E_ACK
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_GAP} state_t;

  state_t         state_q;
  logic           gnt_b_q;
  logic           last_b_q;
  logic           we_q;
  logic [10:0]    addr_q;
  logic [7:0]     wdata_q;
  logic           err_q;
  logic           e_wr_q;
  logic           e_rd_q;
  logic           a_done_q, b_done_q;
  logic           a_err_q, b_err_q;
  logic [7:0]     a_rdata_q, b_rdata_q;
  logic [CW-1:0]  cnt_q;
  logic [GW-1:0]  gap_q;
  logic           pick_b_d;
  logic           timeout_d;

  // last_b_q resets high so port A wins the first tie.
  always_comb begin
    pick_b_d  = B_REQ && (!A_REQ || !last_b_q);
    timeout_d = (cnt_q == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      e_wr_q    <= 1'b0;
      e_rd_q    <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
    end else begin
      e_wr_q   <= 1'b0;
      e_rd_q   <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      a_err_q  <= 1'b0;
      b_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (A_REQ || B_REQ) begin
            gnt_b_q <= pick_b_d;
            we_q    <= pick_b_d ? B_WE    : A_WE;
            addr_q  <= pick_b_d ? B_ADDR  : A_ADDR;
            wdata_q <= pick_b_d ? B_WDATA : A_WDATA;
            e_wr_q  <= pick_b_d ? B_WE    : A_WE;
            e_rd_q  <= pick_b_d ? !B_WE   : !A_WE;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // ACK takes priority over a coincident timeout.
          if (E_ACK || timeout_d) begin
            err_q    <= !E_ACK;
            a_done_q <= !gnt_b_q;
            b_done_q <= gnt_b_q;
            a_err_q  <= !gnt_b_q && !E_ACK;
            b_err_q  <= gnt_b_q && !E_ACK;
            if (E_ACK && !we_q && !gnt_b_q) a_rdata_q <= E_DATA;
            if (E_ACK && !we_q && gnt_b_q)  b_rdata_q <= E_DATA;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          last_b_q <= gnt_b_q;
          gap_q    <= '0;
          state_q  <= (we_q && !err_q && (WR_GAP > 0)) ? S_GAP : S_IDLE;
        end
        S_GAP: begin
          gap_q <= gap_q + GW'(1);
          if (gap_q == GW'(WR_GAP - 1)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign E_WR    = e_wr_q;
  assign E_RD    = e_rd_q;
  assign E_ADDR  = addr_q;
  assign A_DONE  = a_done_q;
  assign B_DONE  = b_done_q;
  assign A_ERR   = a_err_q;
  assign B_ERR   = b_err_q;
  assign A_RDATA = a_rdata_q;
  assign B_RDATA = b_rdata_q;

  assign E_DATA = (we_q && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_DONE))
                  ? wdata_q : 8'hzz;

endmodule

// File: doc/eeprom_arbiter.md
Name: eeprom_arbiter

Overview:
- Two-port arbiter and sequencer in front of the I2C EEPROM read/write engine (EEPROM_WR).
- Two independent requesters (port A, port B) each issue single-byte read or write transactions.
- The block grants the engine round-robin, pulses the engine's WR/RD strobe and holds ADDR/DATA stable until the engine's ACK.
- It returns read data and a done pulse to the winner, enforces a post-write recovery gap (EEPROM tWR), and times out a hung engine.

Parameters:
- TIMEOUT, 4096: max cycles in WAIT_ACK before abort; counter width is clog2(TIMEOUT).
- WR_GAP, 1024: idle cycles enforced after every completed write; 0 disables the gap.

Ports:
- CLK  input  1  system clock, all flops on posedge.
- RESET  input  1  asynchronous, active-low reset.
- A_REQ  input  1  port A request, level; held until A_DONE.
- A_WE  input  1  port A: 1 = write, 0 = read; valid while A_REQ.
- A_ADDR  input  11  port A byte address.
- A_WDATA  input  8  port A write byte.
- A_DONE  output  1  one-cycle completion pulse to port A.
- A_ERR  output  1  qualifies A_DONE: transaction timed out.
- A_RDATA  output  8  port A read byte; valid from A_DONE until A's next completion.
- B_REQ, B_WE, B_ADDR, B_WDATA, B_DONE, B_ERR, B_RDATA: identical to the A ports, for port B.
- E_WR  output  1  engine write strobe.
- E_RD  output  1  engine read strobe.
- E_ADDR  output  11  engine address.
- E_DATA  inout  8  engine parallel data bus.
- E_ACK  input  1  engine completion, sampled synchronously.

Behaviour:
- Reset, asynchronous on RESET low:
  - state = IDLE.
  - E_WR = E_RD = 0; E_ADDR = 0; E_DATA released (Z).
  - A_/B_DONE = 0, A_/B_ERR = 0, A_/B_RDATA = 8'h00.
  - Counters cleared; last_gnt = B, so A wins the first tie.
- Reset mid-transaction aborts immediately:
  - No DONE pulse is produced.
  - Requesters must re-request.
- IDLE:
  - If only one REQ is high, grant it.
  - If both are high, grant the port opposite last_gnt.
  - On grant, latch gnt, WE, ADDR and WDATA into internal regs, then go to ISSUE.
  - Inputs are not re-sampled until the next IDLE.
- ISSUE (exactly 1 cycle):
  - E_WR = latched WE, E_RD = ~latched WE.
  - E_ADDR = latched ADDR.
  - Clear the timeout counter; go to WAIT_ACK.
  - E_WR and E_RD are never both high and never high outside ISSUE.
- WAIT_ACK:
  - Strobes are low; E_ADDR is held; the counter increments each cycle.
  - If E_ACK = 1: for a read, capture E_DATA into the granted port's RDATA; go to DONE with err = 0.
  - Else if counter == TIMEOUT-1: go to DONE with err = 1; RDATA is unchanged.
  - If E_ACK and the timeout coincide, the ACK wins (err = 0).
- DONE (1 cycle):
  - Granted port's DONE = 1 and ERR = err; the other port's DONE and ERR are 0.
  - last_gnt = gnt.
  - Next state is GAP if the transaction was a write, err = 0 and WR_GAP > 0; otherwise IDLE.
- GAP:
  - Count WR_GAP cycles, then go to IDLE.
  - REQs are ignored during GAP; pending requests are served afterwards.
- E_DATA drive:
  - Driven with the latched WDATA from ISSUE through DONE for writes.
  - Z in all other states and for reads.
- Latency:
  - REQ high in IDLE at cycle 0 → E_WR/E_RD at cycle 1 → WAIT_ACK from cycle 2.
  - DONE is one cycle after the E_ACK cycle.
  - Minimum turnaround with WR_GAP = 0 is 4 cycles plus the engine time.
- Requester rule: drop REQ by the cycle after DONE; a REQ still high in IDLE is treated as a new request.
- A transaction starts only from IDLE; E_ACK outside WAIT_ACK is ignored.

Test Plan:
- A write (A_ADDR = 11'h155, A_WDATA = 8'hA5), engine acks 40 cycles after E_WR → one-cycle E_WR at cycle 1 with E_ADDR = 11'h155, E_DATA = 8'hA5 held through DONE, A_DONE = 1 with A_ERR = 0, then WR_GAP = 16 idle cycles before any new E_WR.
- B read at 11'h7FF, engine drives E_DATA = 8'h3C with E_ACK → B_RDATA = 8'h3C from B_DONE onward, E_DATA undriven by the arbiter throughout, E_WR never high.
- A_REQ and B_REQ asserted together after reset, both held until done → A served first, then B, then A again; grants alternate while both stay asserted.
- E_ACK never asserted with TIMEOUT = 64 → DONE at cycle 66 after issue with ERR = 1, no GAP, RDATA unchanged, next request is accepted.
- RESET pulsed low during WAIT_ACK → all outputs at reset values asynchronously, no DONE pulse; after release, a held A_REQ restarts with E_WR at cycle 1.
- E_ACK in the same cycle the counter hits TIMEOUT-1 → ERR = 0 and read data captured; a spurious E_ACK in IDLE → no DONE pulse.
